// File: rtl/imem_rom_loader_if.sv
// Fetch-side ROM ports and the byte-serial program loader handshake of imem_rom_loader.
// The slave modport is the memory side, and the master modport is the CPU/loader side.
interface imem_rom_loader_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] ROM_A1;
   logic [ADDR_W-1:0] ROM_A2;
   logic [DATA_W-1:0] ROM_RD1;
   logic [DATA_W-1:0] ROM_RD2;
   logic              ld_start;
   logic [ADDR_W:0]   ld_len;
   logic [7:0]        ld_byte;
   logic              ld_valid;
   logic              ld_ready;
   logic              ld_busy;
   logic              ld_done;
   logic              ld_err;
   logic              CPU_RST;

   modport slave (
      input  ROM_A1, ROM_A2, ld_start, ld_len, ld_byte, ld_valid,
      output ROM_RD1, ROM_RD2, ld_ready, ld_busy, ld_done, ld_err, CPU_RST
   );

   modport master (
      output ROM_A1, ROM_A2, ld_start, ld_len, ld_byte, ld_valid,
      input  ROM_RD1, ROM_RD2, ld_ready, ld_busy, ld_done, ld_err, CPU_RST
   );
endinterface

// File: rtl/imem_rom_loader.sv
// Dual-read-port instruction memory with a big-endian byte-serial loader.
// The CPU is held in reset while a program streams in.
//
// state | meaning
// IDLE  | memory readable, waiting for ld_start
// LOAD  | accepting bytes, read ports return NOP, CPU held in reset
// DONE  | one-cycle ld_done pulse, CPU still held in reset
module imem_rom_loader #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input logic                CLK,
   input logic                RST,
   imem_rom_loader_if.slave   bus
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0]   waddr;
   logic [1:0]          bidx;
   logic [ADDR_W:0]     remaining;
   logic [DATA_W-9:0]   shreg;
   logic                ld_err_q;
   logic                start_ok, start_bad, accept, word_wr;
   logic [DATA_W-1:0]   word;

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      start_bad = 1'b0;
      accept    = 1'b0;
      word_wr   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.ld_start) begin
               if (bus.ld_len != '0 && bus.ld_len <= (ADDR_W+1)'(DEPTH)) begin
                  start_ok  = 1'b1;
                  state_nxt = S_LOAD;
               end else begin
                  start_bad = 1'b1;
               end
            end
         end
         S_LOAD: begin
            accept  = bus.ld_valid;
            word_wr = bus.ld_valid && (bidx == 2'd3);
            if (word_wr && remaining == (ADDR_W+1)'(1))
               state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         waddr     <= '0;
         bidx      <= '0;
         remaining <= '0;
         shreg     <= '0;
         ld_err_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            waddr     <= '0;
            bidx      <= '0;
            remaining <= bus.ld_len;
            ld_err_q  <= 1'b0;
         end else if (start_bad) begin
            ld_err_q  <= 1'b1;
         end
         if (accept) begin
            bidx  <= bidx + 2'd1;
            shreg <= {shreg[DATA_W-17:0], bus.ld_byte};
         end
         if (word_wr) begin
            waddr     <= waddr + 1'b1;
            remaining <= remaining - 1'b1;
         end
      end
   end

   // First byte received ends up in the top byte of the word.
   assign word = {shreg, bus.ld_byte};

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (word_wr) begin
         mem[waddr] <= word;
      end
   end

   assign bus.ROM_RD1  = (state == S_IDLE) ? mem[bus.ROM_A1] : '0;
   assign bus.ROM_RD2  = (state == S_IDLE) ? mem[bus.ROM_A2] : '0;
   assign bus.ld_ready = (state == S_LOAD);
   assign bus.ld_busy  = (state != S_IDLE);
   assign bus.ld_done  = (state == S_DONE);
   assign bus.ld_err   = ld_err_q;
   assign bus.CPU_RST  = RST | (state != S_IDLE);
endmodule

// File: tb/tb_imem_rom_loader.sv
// Self-checking bench for imem_rom_loader with a plain-array memory model.
// Loads are streamed from a byte queue, and the expected words are assembled from that queue.
module tb_imem_rom_loader;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [31:0] model_mem [64];
   logic [7:0]  ld_q [$];

   imem_rom_loader_if #(.ADDR_W(6), .DATA_W(32)) bf ();
   imem_rom_loader #(.ADDR_W(6), .DATA_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bf));

   always #5 CLK = ~CLK;

   initial begin
      #3_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic verify_mem(input string tag);
      for (int a = 0; a < 64; a++) begin
         bf.ROM_A1 = 6'(a);
         bf.ROM_A2 = 6'(63 - a);
         #1;
         n_cmp++; if (bf.ROM_RD1 !== model_mem[a]) begin n_err++; $display("FAIL %s rd1[%0d] got %h exp %h", tag, a, bf.ROM_RD1, model_mem[a]); end
         n_cmp++; if (bf.ROM_RD2 !== model_mem[63-a]) begin n_err++; $display("FAIL %s rd2[%0d] got %h exp %h", tag, 63-a, bf.ROM_RD2, model_mem[63-a]); end
      end
   endtask

   // mode 0: ld_valid always high, 1: toggling starting low, 2: random with stray ld_start
   task automatic run_load(input int len, input int mode, input string tag, output int load_cycles);
      int idx = 0;
      int cyc = 0;
      bf.ld_start = 1'b1;
      bf.ld_len   = 7'(len);
      bf.ld_valid = 1'b0;
      tick();
      bf.ld_start = 1'b0;
      n_cmp++; if (bf.ld_err !== 1'b0) begin n_err++; $display("FAIL %s err_after_start got %b exp 0", tag, bf.ld_err); end
      n_cmp++; if (bf.ld_busy !== 1'b1 || bf.CPU_RST !== 1'b1) begin n_err++; $display("FAIL %s busy_cpurst got %b%b exp 11", tag, bf.ld_busy, bf.CPU_RST); end
      while (idx < 4 * len && cyc < 4000) begin
         case (mode)
            0: bf.ld_valid = 1'b1;
            1: bf.ld_valid = cyc[0];
            default: begin
               bf.ld_valid = ($urandom_range(99) < 60);
               bf.ld_start = ($urandom_range(9) == 0);
               bf.ld_len   = 7'($urandom_range(127));
            end
         endcase
         bf.ld_byte = bf.ld_valid ? ld_q[idx] : 8'($urandom);
         bf.ROM_A1  = 6'($urandom);
         bf.ROM_A2  = 6'($urandom);
         #1;
         n_cmp++; if (bf.ld_ready !== 1'b1 || bf.ld_done !== 1'b0) begin n_err++; $display("FAIL %s load_ready_done cyc %0d got %b%b exp 10", tag, cyc, bf.ld_ready, bf.ld_done); end
         n_cmp++; if (bf.ROM_RD1 !== 32'h0 || bf.ROM_RD2 !== 32'h0) begin n_err++; $display("FAIL %s load_nop cyc %0d got %h %h exp 0", tag, cyc, bf.ROM_RD1, bf.ROM_RD2); end
         if (bf.ld_valid) idx++;
         cyc++;
         tick();
      end
      bf.ld_valid = 1'b0;
      bf.ld_start = 1'b0;
      load_cycles = cyc;
      n_cmp++; if (idx != 4 * len) begin n_err++; $display("FAIL %s byte_budget got %0d exp %0d", tag, idx, 4 * len); end
      #1;
      n_cmp++; if (bf.ld_done !== 1'b1 || bf.ld_ready !== 1'b0 || bf.CPU_RST !== 1'b1) begin n_err++; $display("FAIL %s done_cycle got done=%b ready=%b cpu_rst=%b exp 1 0 1", tag, bf.ld_done, bf.ld_ready, bf.CPU_RST); end
      n_cmp++; if (bf.ROM_RD1 !== 32'h0) begin n_err++; $display("FAIL %s done_nop got %h exp 0", tag, bf.ROM_RD1); end
      for (int w = 0; w < len; w++)
         model_mem[w] = {ld_q[4*w], ld_q[4*w+1], ld_q[4*w+2], ld_q[4*w+3]};
      tick();
      n_cmp++; if (bf.ld_done !== 1'b0 || bf.ld_busy !== 1'b0 || bf.CPU_RST !== 1'b0) begin n_err++; $display("FAIL %s after_done got done=%b busy=%b cpu_rst=%b exp 0 0 0", tag, bf.ld_done, bf.ld_busy, bf.CPU_RST); end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      bf.ROM_A1 = 6'd0;
      bf.ROM_A2 = 6'd63;
      tick();
      tick();
      n_cmp++; if (bf.ROM_RD1 !== 32'h0 || bf.ROM_RD2 !== 32'h0) begin n_err++; $display("FAIL reset_rd got %h %h exp 0 0", bf.ROM_RD1, bf.ROM_RD2); end
      n_cmp++; if (bf.CPU_RST !== 1'b1) begin n_err++; $display("FAIL reset_cpu_rst got %b exp 1", bf.CPU_RST); end
      n_cmp++; if ({bf.ld_ready, bf.ld_busy, bf.ld_done, bf.ld_err} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b exp 0000", {bf.ld_ready, bf.ld_busy, bf.ld_done, bf.ld_err}); end
      RST = 1'b0;
      #1;
      n_cmp++; if (bf.CPU_RST !== 1'b0) begin n_err++; $display("FAIL reset_release got %b exp 0", bf.CPU_RST); end
      tick();
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
   endtask

   task automatic test_basic_load();
      int cyc;
      ld_q = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
      run_load(2, 0, "basic", cyc);
      n_cmp++; if (cyc != 8) begin n_err++; $display("FAIL basic_cycles got %0d exp 8", cyc); end
      bf.ROM_A1 = 6'd0;
      bf.ROM_A2 = 6'd1;
      #1;
      n_cmp++; if (bf.ROM_RD1 !== 32'h24080005) begin n_err++; $display("FAIL basic_w0 got %h exp 24080005", bf.ROM_RD1); end
      n_cmp++; if (bf.ROM_RD2 !== 32'h01095020) begin n_err++; $display("FAIL basic_w1 got %h exp 01095020", bf.ROM_RD2); end
   endtask

   task automatic test_bubbles();
      int cyc;
      for (int i = 0; i < 64; i++) model_mem[i] = (i < 2) ? model_mem[i] : 32'h0;
      ld_q = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
      run_load(2, 1, "bubbles", cyc);
      n_cmp++; if (cyc != 16) begin n_err++; $display("FAIL bubbles_cycles got %0d exp 16", cyc); end
      verify_mem("bubbles");
   endtask

   task automatic test_err();
      int cyc;
      bf.ld_start = 1'b1; bf.ld_len = 7'd0;
      tick();
      bf.ld_start = 1'b0;
      n_cmp++; if (bf.ld_err !== 1'b1 || bf.ld_ready !== 1'b0 || bf.ld_busy !== 1'b0) begin n_err++; $display("FAIL err_len0 got err=%b ready=%b busy=%b exp 1 0 0", bf.ld_err, bf.ld_ready, bf.ld_busy); end
      bf.ld_start = 1'b1; bf.ld_len = 7'd65;
      tick();
      bf.ld_start = 1'b0;
      n_cmp++; if (bf.ld_err !== 1'b1 || bf.ld_busy !== 1'b0 || bf.CPU_RST !== 1'b0) begin n_err++; $display("FAIL err_len65 got err=%b busy=%b cpu_rst=%b exp 1 0 0", bf.ld_err, bf.ld_busy, bf.CPU_RST); end
      // ld_valid in IDLE must not disturb memory or the sticky error.
      for (int i = 0; i < 6; i++) begin
         bf.ld_valid = 1'b1; bf.ld_byte = 8'($urandom);
         tick();
      end
      bf.ld_valid = 1'b0;
      n_cmp++; if (bf.ld_err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b exp 1", bf.ld_err); end
      verify_mem("idle_valid");
      ld_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_load(1, 0, "err_clear", cyc);
      n_cmp++; if (bf.ld_err !== 1'b0) begin n_err++; $display("FAIL err_cleared got %b exp 0", bf.ld_err); end
      verify_mem("err_clear");
   endtask

   task automatic test_full_load();
      int cyc;
      ld_q = {};
      for (int i = 0; i < 64; i++) repeat (4) ld_q.push_back(8'(i));
      run_load(64, 0, "full", cyc);
      n_cmp++; if (cyc != 256) begin n_err++; $display("FAIL full_cycles got %0d exp 256", cyc); end
      bf.ROM_A1 = 6'd63;
      #1;
      n_cmp++; if (bf.ROM_RD1 !== 32'h3F3F3F3F) begin n_err++; $display("FAIL full_63 got %h exp 3f3f3f3f", bf.ROM_RD1); end
      bf.ROM_A1 = 6'd17; bf.ROM_A2 = 6'd17;
      #1;
      n_cmp++; if (bf.ROM_RD1 !== 32'h11111111 || bf.ROM_RD2 !== 32'h11111111) begin n_err++; $display("FAIL full_17 got %h %h exp 11111111", bf.ROM_RD1, bf.ROM_RD2); end
      verify_mem("full");
   endtask

   task automatic test_rst_abort();
      int cyc;
      bf.ld_start = 1'b1; bf.ld_len = 7'd3;
      tick();
      bf.ld_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bf.ld_valid = 1'b1; bf.ld_byte = 8'($urandom);
         tick();
      end
      bf.ld_valid = 1'b0;
      RST = 1'b1;
      tick();
      n_cmp++; if (bf.ld_busy !== 1'b0 || bf.ld_done !== 1'b0 || bf.CPU_RST !== 1'b1) begin n_err++; $display("FAIL abort_rst got busy=%b done=%b cpu_rst=%b exp 0 0 1", bf.ld_busy, bf.ld_done, bf.CPU_RST); end
      RST = 1'b0;
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
      tick();
      n_cmp++; if (bf.ld_done !== 1'b0 || bf.ld_ready !== 1'b0 || bf.CPU_RST !== 1'b0) begin n_err++; $display("FAIL abort_idle got done=%b ready=%b cpu_rst=%b exp 0 0 0", bf.ld_done, bf.ld_ready, bf.CPU_RST); end
      verify_mem("abort_clear");
      ld_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
      run_load(1, 0, "abort_reload", cyc);
      verify_mem("abort_reload");
   endtask

   task automatic test_random_loads();
      int cyc;
      for (int t = 0; t < 6; t++) begin
         int len = (t == 0) ? 64 : $urandom_range(64, 1);
         ld_q = {};
         for (int b = 0; b < 4 * len; b++) ld_q.push_back(8'($urandom));
         run_load(len, 2, $sformatf("rand%0d", t), cyc);
         for (int k = 0; k < 20; k++) begin
            int a1 = $urandom_range(63);
            int a2 = (k % 5 == 0) ? a1 : $urandom_range(63);
            bf.ROM_A1 = 6'(a1); bf.ROM_A2 = 6'(a2);
            #1;
            n_cmp++; if (bf.ROM_RD1 !== model_mem[a1] || bf.ROM_RD2 !== model_mem[a2]) begin n_err++; $display("FAIL rand%0d rd a=%0d/%0d got %h %h exp %h %h", t, a1, a2, bf.ROM_RD1, bf.ROM_RD2, model_mem[a1], model_mem[a2]); end
         end
      end
      verify_mem("rand_final");
   endtask

   initial begin
      bf.ROM_A1 = '0; bf.ROM_A2 = '0;
      bf.ld_start = 1'b0; bf.ld_len = '0; bf.ld_byte = '0; bf.ld_valid = 1'b0;
      test_reset();
      test_basic_load();
      test_bubbles();
      test_err();
      test_full_load();
      test_rst_abort();
      test_random_loads();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/imem_rom_loader.md
# imem_rom_loader

Dual-read-port 64×32 instruction memory that answers the CPU fetch stage's two ROM address/data port pairs. It includes a byte-serial program loader with a valid/ready handshake. While a program is streamed in, the block holds the CPU in reset and returns NOPs on both read ports. When the last word is committed, it releases the CPU to fetch from address 0.

## Interface
- ADDR_W, 6, word-address width; depth = 2^ADDR_W = 64 words
- DATA_W, 32, instruction width
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- ROM_A1  input  ADDR_W  fetch word address, port 1
- ROM_A2  input  ADDR_W  fetch word address, port 2
- ROM_RD1  output  DATA_W  instruction at ROM_A1
- ROM_RD2  output  DATA_W  instruction at ROM_A2
- ld_start  input  1  one-cycle request to begin a load; sampled only in IDLE
- ld_len  input  ADDR_W+1  number of words to load, 1..64; sampled with ld_start
- ld_byte  input  8  load data byte
- ld_valid  input  1  ld_byte is valid
- ld_ready  output  1  block accepts ld_byte this cycle
- ld_busy  output  1  load in progress (LOAD or DONE state)
- ld_done  output  1  one-cycle pulse after the final word is written
- ld_err  output  1  sticky: illegal ld_len seen; cleared by RST or the next legal ld_start
- CPU_RST  output  1  reset to the CPU core; high during RST, LOAD and DONE

## Operation
- Read path:
  - Combinational, zero latency: ROM_RDn = mem[ROM_An] in IDLE.
  - In LOAD and DONE, both ROM_RDn = 32'h0 (NOP).
  - A1 == A2 is legal; both ports return the same word.
- States: IDLE, LOAD, DONE.
- IDLE:
  - ld_ready = 0.
  - On ld_start with 1 ≤ ld_len ≤ 64, go to LOAD and clear: word address waddr = 0, byte index bidx = 0, remaining = ld_len, ld_err = 0.
  - On ld_start with ld_len == 0 or ld_len > 64, set ld_err and stay in IDLE.
  - ld_valid is ignored in IDLE.
- LOAD:
  - ld_ready = 1.
  - Each cycle with ld_valid & ld_ready, one byte is accepted into a 32-bit shift register, big-endian: the first byte of a word lands in [31:24], the 4th in [7:0].
  - bidx increments mod 4.
  - On acceptance of the byte with bidx == 3:
    - mem[waddr] ← assembled word, written at that same edge.
    - waddr increments; remaining decrements.
    - If remaining was 1, go to DONE.
  - ld_valid low inserts bubbles with no effect on state.
  - ld_start is ignored in LOAD.
- DONE: lasts one cycle; ld_done = 1, ld_ready = 0, then go to IDLE.
- Words at addresses ≥ ld_len keep their previous contents.
- waddr never wraps, because ld_len ≤ 64 is enforced.
- CPU_RST = RST | (state != IDLE). The CPU therefore leaves reset in the first IDLE cycle after DONE.
- RST effects:
  - All 64 words are cleared to 0 in one cycle.
  - State → IDLE, counters → 0, ld_err → 0.
  - RST asserted mid-LOAD aborts the load and discards the partial word.

## Timing
- Reset values (cycle after RST high): ld_ready 0, ld_busy 0, ld_done 0, ld_err 0, CPU_RST 1 (follows RST), ROM_RD1/ROM_RD2 = 0 (memory cleared).
- In the first cycle with RST low: CPU_RST 0, state IDLE.
- ld_start accepted at edge T: state is LOAD from T+1; ld_ready, ld_busy and CPU_RST are high from T+1.
- Maximum throughput is one byte per cycle. A load of N words with ld_valid held high takes 4N LOAD cycles plus 1 DONE cycle.
- After the final byte is accepted at edge T:
  - The word is visible in memory from T+1.
  - T+1 is the DONE cycle: ld_done = 1, ROM_RD = 0.
  - From T+2: IDLE, CPU_RST = 0, ROM_RD shows loaded data.
- ld_err is set at the edge following the illegal ld_start.

## Test plan
- Reset: RST high 2 cycles with ROM_A1=0, ROM_A2=63 → ROM_RD1=ROM_RD2=0, CPU_RST=1, ld_ready=0. After release → CPU_RST=0.
- Load 2 words, bytes 8'h24,8'h08,8'h00,8'h05,8'h01,8'h09,8'h50,8'h20 streamed back-to-back:
  - ld_ready high for 8 cycles, ld_done pulses on cycle 9.
  - Afterwards ROM_A1=0 → ROM_RD1=32'h24080005 and ROM_A2=1 → ROM_RD2=32'h01095020; CPU_RST low from cycle 10.
- Same load with ld_valid toggling every other cycle → identical memory contents, done after 16 LOAD cycles; ROM_RD1/RD2 = 0 throughout LOAD.
- ld_start with ld_len=0, then ld_len=65 → ld_err=1, state stays IDLE, ld_ready=0. A following legal ld_start (len=1) clears ld_err.
- Full 64-word load of pattern word i = {4{i[7:0]}} → ROM_A1=63 returns 32'h3F3F3F3F, ROM_A1=ROM_A2=17 both return 32'h11111111.
- RST asserted after 6 bytes of a 3-word load → memory all 0, state IDLE, no ld_done. A new 1-word load afterwards succeeds at address 0.
